// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB master port among MASTERS requesters, with an ACCESS watchdog.
// Grant to ack takes 3 cycles plus slave wait states; losing requesters hold req until their own ack.
module apb_arbiter #(
  parameter int MASTERS    = 4,
  parameter int PADDR_SIZE = 16,
  parameter int PDATA_SIZE = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [MASTERS-1:0]            req,
  input  logic [MASTERS*PADDR_SIZE-1:0] addr,
  input  logic [MASTERS-1:0]            write,
  input  logic [MASTERS*PDATA_SIZE-1:0] wdata,
  output logic [MASTERS-1:0]            gnt,
  output logic [MASTERS-1:0]            ack,
  output logic                          err,
  output logic [PDATA_SIZE-1:0]         rdata,
  output logic                          timeout,
  output logic                          PSEL,
  output logic                          PENABLE,
  output logic [PADDR_SIZE-1:0]         PADDR,
  output logic                          PWRITE,
  output logic [PDATA_SIZE-1:0]         PWDATA,
  input  logic [PDATA_SIZE-1:0]         PRDATA,
  input  logic                          PREADY,
  input  logic                          PSLVERR
);

  localparam int IW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t                  state_q;
  logic [IW-1:0]           last_q;
  logic [IW-1:0]           sel_q;
  logic [CW-1:0]           cnt_q;
  logic [MASTERS-1:0]      gnt_q;
  logic [MASTERS-1:0]      ack_q;
  logic                    err_q;
  logic [PDATA_SIZE-1:0]   rdata_q;
  logic                    timeout_q;
  logic                    psel_q;
  logic                    penable_q;
  logic [PADDR_SIZE-1:0]   paddr_q;
  logic                    pwrite_q;
  logic [PDATA_SIZE-1:0]   pwdata_q;

  logic                    pick_vld;
  logic [IW-1:0]           pick_idx;
  logic [MASTERS-1:0]      pick_gnt;
  logic [PADDR_SIZE-1:0]   pick_addr;
  logic                    pick_wr;
  logic [PDATA_SIZE-1:0]   pick_wdat;

  // Pass 0 looks only above the last winner, pass 1 wraps round from requester 0.
  always_comb begin
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_gnt  = '0;
    pick_addr = '0;
    pick_wr   = 1'b0;
    pick_wdat = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < MASTERS; i++) begin
        if (!pick_vld && req[i] && ((p == 1) || (IW'(i) > last_q))) begin
          pick_vld    = 1'b1;
          pick_idx    = IW'(i);
          pick_gnt[i] = 1'b1;
          pick_addr   = addr[i*PADDR_SIZE +: PADDR_SIZE];
          pick_wr     = write[i];
          pick_wdat   = wdata[i*PDATA_SIZE +: PDATA_SIZE];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      last_q    <= IW'(MASTERS - 1);
      sel_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      ack_q     <= '0;
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pick_vld) begin
            sel_q    <= pick_idx;
            gnt_q    <= pick_gnt;
            paddr_q  <= pick_addr;
            pwrite_q <= pick_wr;
            pwdata_q <= pick_wdat;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // A ready slave wins over a watchdog expiring in the same cycle.
          if (PREADY) begin
            err_q     <= PSLVERR;
            rdata_q   <= pwrite_q ? '0 : PRDATA;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= gnt_q;
            state_q   <= DONE;
          end else if ((TIMEOUT > 0) && (cnt_q == TO_LAST)) begin
            err_q     <= 1'b1;
            rdata_q   <= '0;
            timeout_q <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            ack_q     <= gnt_q;
            state_q   <= DONE;
          end else if (TIMEOUT > 0) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          gnt_q   <= '0;
          last_q  <= sel_q;
          err_q   <= 1'b0;
          rdata_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign timeout = timeout_q;
  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: scoreboard of expected completions checked on every ack, plus a simple APB slave.
module tb_apb_arbiter;
  localparam int M  = 4;
  localparam int AW = 16;
  localparam int DW = 8;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [M-1:0]      req = '0;
  logic [M*AW-1:0]   addr = '0;
  logic [M-1:0]      write = '0;
  logic [M*DW-1:0]   wdata = '0;
  logic [M-1:0]      gnt;
  logic [M-1:0]      ack;
  logic              err;
  logic [DW-1:0]     rdata;
  logic              timeout;
  logic              PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  apb_arbiter #(.MASTERS(M), .PADDR_SIZE(AW), .PDATA_SIZE(DW), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req(req), .addr(addr), .write(write), .wdata(wdata),
    .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .timeout(timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    int          idx;
    logic        err;
    logic [DW-1:0] rdata;
    logic        tmo;
    logic [AW-1:0] paddr;
    logic        pwrite;
    logic [DW-1:0] pwdata;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int slv_wait = 0;
  int acc_cnt = 0;
  int rem[M];

  always @(posedge PCLK) cyc <= cyc + 1;

  // Slave: ready after slv_wait ACCESS cycles; a negative slv_wait never answers.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      PREADY = (slv_wait >= 0) && (acc_cnt == slv_wait);
      acc_cnt = acc_cnt + 1;
    end else begin
      PREADY = 1'b0;
      acc_cnt = 0;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d, int n);
    req[i] = 1'b1;
    write[i] = wr;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    rem[i] = n;
  endtask

  task automatic expect_xfer(int i, logic wr, logic [AW-1:0] a, logic [DW-1:0] d,
                             logic e, logic [DW-1:0] rd, logic tmo, int lat);
    exp_t x;
    x.idx = i; x.err = e; x.rdata = rd; x.tmo = tmo; x.paddr = a;
    x.pwrite = wr; x.pwdata = d; x.lat = lat; x.t0 = cyc;
    sb.push_back(x);
  endtask

  task automatic step();
    exp_t e;
    @(negedge PCLK);
    if (ack != '0) begin
      check("ack_onehot", 32'($onehot(ack)), 32'd1);
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'(ack), 32'd0);
      end else begin
        e = sb.pop_front();
        check("ack_idx", 32'(ack), 32'd1 << e.idx);
        check("gnt_idx", 32'(gnt), 32'd1 << e.idx);
        check("err", 32'(err), 32'(e.err));
        check("rdata", 32'(rdata), 32'(e.rdata));
        check("timeout", 32'(timeout), 32'(e.tmo));
        check("paddr", 32'(PADDR), 32'(e.paddr));
        check("pwrite", 32'(PWRITE), 32'(e.pwrite));
        check("pwdata", 32'(PWDATA), 32'(e.pwdata));
        check("bus_off_in_done", 32'({PSEL, PENABLE}), 32'd0);
        if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
      end
      for (int k = 0; k < M; k++) begin
        if (ack[k]) begin
          rem[k]--;
          if (rem[k] <= 0) req[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic run(int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      check("ack_budget", 32'(sb.size()), 32'd0);
      sb.delete();
      req = '0;
    end
    step();
    step();
  endtask

  initial begin
    int n;
    for (int k = 0; k < M; k++) rem[k] = 0;

    // Reset values
    PRESETn = 1'b0;
    step(); step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_bus", 32'({PSEL, PENABLE, PWRITE}), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_status", 32'({err, timeout, rdata}), 32'd0);
    PRESETn = 1'b1;

    // Zero-wait write from requester 2
    slv_wait = 0; PRDATA = 8'h99; PSLVERR = 1'b0;
    issue(2, 1'b1, 16'h1234, 8'hA5, 1);
    expect_xfer(2, 1'b1, 16'h1234, 8'hA5, 1'b0, 8'h00, 1'b0, 3);
    step();
    check("t1_setup_psel", 32'(PSEL), 32'd1);
    check("t1_setup_pen", 32'(PENABLE), 32'd0);
    check("t1_setup_paddr", 32'(PADDR), 32'h1234);
    step();
    check("t1_access_bus", 32'({PSEL, PENABLE}), 32'd3);
    check("t1_access_pwdata", 32'(PWDATA), 32'hA5);
    run(10);
    check("t1_idle_gnt", 32'(gnt), 32'd0);

    // Round robin from a fresh pointer: 0,1,3,0
    PRESETn = 1'b0; step(); PRESETn = 1'b1;
    PRDATA = 8'h4D;
    issue(0, 1'b0, 16'h0100, 8'h10, 2);
    issue(1, 1'b1, 16'h0200, 8'h21, 1);
    issue(3, 1'b0, 16'h0300, 8'h33, 1);
    expect_xfer(0, 1'b0, 16'h0100, 8'h10, 1'b0, 8'h4D, 1'b0, 3);
    expect_xfer(1, 1'b1, 16'h0200, 8'h21, 1'b0, 8'h00, 1'b0, -1);
    expect_xfer(3, 1'b0, 16'h0300, 8'h33, 1'b0, 8'h4D, 1'b0, -1);
    expect_xfer(0, 1'b0, 16'h0100, 8'h10, 1'b0, 8'h4D, 1'b0, -1);
    run(60);

    // Read, 3 wait states, slave error
    slv_wait = 3; PRDATA = 8'h5C; PSLVERR = 1'b1;
    issue(1, 1'b0, 16'hBEEF, 8'h00, 1);
    expect_xfer(1, 1'b0, 16'hBEEF, 8'h00, 1'b1, 8'h5C, 1'b0, 6);
    run(20);

    // Watchdog expiry: 4 ACCESS cycles then forced error
    slv_wait = -1; PRDATA = 8'hEE; PSLVERR = 1'b0;
    issue(3, 1'b0, 16'h0DEA, 8'h44, 1);
    expect_xfer(3, 1'b0, 16'h0DEA, 8'h44, 1'b1, 8'h00, 1'b1, 6);
    run(20);

    // Ready on the last allowed ACCESS cycle completes normally
    slv_wait = 3; PRDATA = 8'h77; PSLVERR = 1'b0;
    issue(2, 1'b0, 16'h0777, 8'h55, 1);
    expect_xfer(2, 1'b0, 16'h0777, 8'h55, 1'b0, 8'h77, 1'b0, 6);
    run(20);

    // Reset during ACCESS, pending requests re-arbitrated from requester 0
    slv_wait = -1;
    issue(3, 1'b1, 16'h0333, 8'h66, 1);
    n = 0;
    while (!(PSEL && PENABLE) && n < 20) begin
      step();
      n++;
    end
    check("t6_reached_access", 32'(PSEL && PENABLE), 32'd1);
    PRESETn = 1'b0;
    issue(1, 1'b0, 16'h0111, 8'h12, 1);
    step();
    check("t6_rst_bus", 32'({PSEL, PENABLE}), 32'd0);
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_ack", 32'(ack), 32'd0);
    PRESETn = 1'b1;
    slv_wait = 0; PRDATA = 8'h3C;
    expect_xfer(1, 1'b0, 16'h0111, 8'h12, 1'b0, 8'h3C, 1'b0, -1);
    expect_xfer(3, 1'b1, 16'h0333, 8'h66, 1'b0, 8'h00, 1'b0, -1);
    run(40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no summary expected summary before limit");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Round-robin arbiter that shares one APB master port between MASTERS requesters.
- Sequences each granted request through the APB SETUP/ACCESS phases and returns the completion, read data and error to the requester.
- Includes an ACCESS-phase watchdog: a slave that never asserts PREADY is ended with an error, so the bus cannot lock up.
- Sits between on-chip requesters and the APB decoder/slave fabric, including the APB error slave.

Parameters:
- MASTERS, 4: number of requesters; 1 or more.
- PADDR_SIZE, 16: APB address width in bits.
- PDATA_SIZE, 8: APB data width in bits.
- TIMEOUT, 255: maximum ACCESS cycles before forced termination; 0 disables the watchdog.

Ports:
- PCLK  input  1  clock, rising edge.
- PRESETn  input  1  reset, synchronous, active-low.
- req  input  MASTERS  per-requester request; held high until its ack.
- addr  input  MASTERS*PADDR_SIZE  per-requester address; slice i belongs to requester i.
- write  input  MASTERS  per-requester direction; 1 = write.
- wdata  input  MASTERS*PDATA_SIZE  per-requester write data.
- gnt  output  MASTERS  one-hot grant; high from SETUP through DONE.
- ack  output  MASTERS  one-hot, single-cycle completion pulse.
- err  output  1  error status; valid with ack.
- rdata  output  PDATA_SIZE  read data; valid with ack.
- timeout  output  1  single-cycle pulse with ack when the watchdog ended the transfer.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PADDR  output  PADDR_SIZE  APB address.
- PWRITE  output  1  APB direction.
- PWDATA  output  PDATA_SIZE  APB write data.
- PRDATA  input  PDATA_SIZE  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB slave error.

Behaviour:
- Reset: PRESETn low at a PCLK edge forces these values, from any state including mid-transfer:
  - state=IDLE; all outputs 0.
  - Round-robin pointer reset so requester 0 has highest priority; watchdog counter cleared.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE:
  - Any req bit high → select the first high bit searching upward from last-granted+1, wrapping modulo MASTERS.
  - Latch that requester's addr/write/wdata into PADDR/PWRITE/PWDATA; set gnt; go to SETUP.
  - No req high → stay in IDLE.
- SETUP: PSEL=1, PENABLE=0; go to ACCESS unconditionally.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PREADY=1 → capture PSLVERR into err; capture PRDATA into rdata on a read, 0 on a write; PSEL=PENABLE=0; go to DONE.
- DONE:
  - ack[granted]=1 for exactly one cycle, with err/rdata valid; then gnt cleared and state=IDLE.
  - Last-granted updated to this requester.
  - No arbitration happens in DONE. The acknowledged requester may keep req high during DONE without being re-granted; it must drop req before the next IDLE cycle unless it wants another transfer.
- Latency: req first sampled high in IDLE at cycle T, zero-wait slave:
  - PSEL at T+1, PENABLE at T+2, ack at T+3, IDLE at T+4.
  - Each wait state adds one cycle.
- Watchdog (TIMEOUT>0):
  - Counter cleared on entry to ACCESS; increments each ACCESS cycle with PREADY=0.
  - Counter reaching TIMEOUT-1 with PREADY still 0 → terminate: PSEL=PENABLE=0, go to DONE with err=1, rdata=0, timeout=1.
  - An ACCESS phase therefore never exceeds TIMEOUT cycles.
  - PREADY=1 in the same cycle as expiry → normal completion takes precedence; timeout=0.
- TIMEOUT=0: watchdog disabled; ACCESS waits indefinitely.
- PADDR/PWRITE/PWDATA:
  - Stable from SETUP through ACCESS.
  - After completion they hold their last value until the next grant.
- req/addr/write/wdata changes after the IDLE grant edge have no effect on the current transfer.
- Requests arriving while a transfer is in progress wait; no pre-emption.
- Simultaneous requests: strict round-robin order; a requester holding req continuously is granted within MASTERS transfers.
- MASTERS=1: pointer logic degenerates; requester 0 is always granted.
- Width rules: addr and wdata slice i is bits [(i+1)*W-1 : i*W].

Test Plan:
- Reset, then req[2]=1, write=1, addr[2]=0x1234, wdata[2]=0xA5; slave PREADY=1 immediately → PSEL T+1, PENABLE T+2, PADDR=0x1234, PWDATA=0xA5, ack[2] at T+3, err=0, rdata=0x00.
- req[0]=req[1]=req[3]=1 held continuously → grants in order 0,1,3,0; gnt one-hot; no two ack in the same cycle.
- Read with 3 wait states, PRDATA=0x5C, PSLVERR=1 on the ready cycle → ack 6 cycles after req, rdata=0x5C, err=1, timeout=0.
- TIMEOUT=4, slave never asserts PREADY → ACCESS lasts exactly 4 cycles, then ack with err=1, timeout=1, rdata=0; PSEL=0 in the DONE cycle.
- TIMEOUT=4, PREADY=1 on the 4th ACCESS cycle with PRDATA=0x77 → normal completion, timeout=0, rdata=0x77.
- PRESETn low for one edge during ACCESS → next cycle PSEL=PENABLE=0, no ack, gnt=0; the pending req is re-granted with requester 0 priority after reset.
